reservoir_readout: RTL and testbench

//  Inference-side counterpart of the linear-regression trainer: applies trained readout weights to the

---
 rtl/reservoir_readout.sv | 189 ++++++++++++++++++
 tb/tb_reservoir_readout.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reservoir_readout.sv
// Reservoir readout: y = w0 + sum(x_i*w_i) via one sequential MAC, plus err = y_target - y.
// Latency: accept to y_valid is exactly N_NEURONS+1 clk edges; one result per N_NEURONS+3 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held with y_valid until y_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake for x_flat, w_flat, y_target
//   x_flat              x1..xN, signed Q1.15, x1 at LSB
//   w_flat              w0..wN, signed Q2.6, bias w0 at LSB
//   y_target            target sample, signed Q1.15
//   y_valid/y_ready     result handshake
//   y_out, err_out, sat saturated readout, saturated error, readout-clipped flag
module reservoir_readout #(
    parameter int N_NEURONS = 19,
    parameter int X_W       = 16,
    parameter int W_W       = 8,
    parameter int FRAC      = 6,
    parameter int ACC_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_NEURONS*X_W-1:0]       x_flat,
    input  logic [(N_NEURONS+1)*W_W-1:0]   w_flat,
    input  logic [X_W-1:0]                 y_target,
    output logic                           y_valid,
    input  logic                           y_ready,
    output logic [X_W-1:0]                 y_out,
    output logic [X_W-1:0]                 err_out,
    output logic                           sat
);

    // idx runs 1..N during accumulation and N+1 for the output step
    localparam int IDX_W = $clog2(N_NEURONS + 2);
    localparam int P_W   = X_W + W_W;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (X_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Snapshots of x1..xN and w1..wN held as shift registers: the current term is always at the LSBs.
    logic [N_NEURONS*X_W-1:0] r_xs;
    logic [N_NEURONS*W_W-1:0] r_ws;
    logic [X_W-1:0]           r_yt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;

    logic signed [X_W-1:0]    w_xi;
    logic signed [W_W-1:0]    w_wi;
    logic signed [P_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias;
    logic signed [ACC_W-1:0]  w_ys;
    logic [X_W-1:0]           w_y;
    logic                     w_sat;
    logic [X_W:0]             w_diff;
    logic [X_W-1:0]           w_err;
    logic                     w_accept;
    logic                     w_last;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_idx == IDX_W'(N_NEURONS + 1));

    assign w_xi       = r_xs[X_W-1:0];
    assign w_wi       = r_ws[W_W-1:0];
    assign w_prod     = w_xi * w_wi;
    assign w_prod_ext = {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};

    // Bias w0 scaled by 1.0 in Q1.15 so it lines up with the x*w products.
    assign w_bias = {{(ACC_W-W_W-X_W+1){w_flat[W_W-1]}}, w_flat[W_W-1:0], {(X_W-1){1'b0}}};

    // Drop the weight fraction bits (arithmetic shift, rounds toward -inf).
    assign w_ys = r_acc >>> FRAC;

    always_comb begin
        w_y   = w_ys[X_W-1:0];
        w_sat = 1'b0;
        if (w_ys > Y_MAX) begin
            w_y   = {1'b0, {(X_W-1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_ys < Y_MIN) begin
            w_y   = {1'b1, {(X_W-1){1'b0}}};
            w_sat = 1'b1;
        end
    end

    // Error computed one bit wider; the top two bits disagree only on overflow.
    assign w_diff = {r_yt[X_W-1], r_yt} - {w_y[X_W-1], w_y};

    always_comb begin
        w_err = w_diff[X_W-1:0];
        if (w_diff[X_W] != w_diff[X_W-1]) begin
            w_err = w_diff[X_W] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (y_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_idx   <= '0;
            y_valid <= 1'b0;
            y_out   <= '0;
            err_out <= '0;
            sat     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc <= w_bias;
                        r_idx <= IDX_W'(1);
                    end
                end
                S_MAC: begin
                    if (w_last) begin
                        y_out   <= w_y;
                        err_out <= w_err;
                        sat     <= w_sat;
                        y_valid <= 1'b1;
                    end else begin
                        r_acc <= r_acc + w_prod_ext;
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                    end
                end
                default: begin
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand snapshot: loaded on accept, shifted one term per MAC step; needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_xs <= x_flat;
            r_ws <= w_flat[(N_NEURONS+1)*W_W-1:W_W];
            r_yt <= y_target;
        end else if (r_state == S_MAC && !w_last) begin
            r_xs <= r_xs >> X_W;
            r_ws <= r_ws >> W_W;
        end
    end

endmodule

// File: tb/tb_reservoir_readout.sv
module tb_reservoir_readout;

    localparam int N   = 19;
    localparam int X_W = 16;
    localparam int W_W = 8;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*X_W-1:0]       x_flat;
    logic [(N+1)*W_W-1:0]   w_flat;
    logic [X_W-1:0]         y_target;
    logic                   y_valid;
    logic                   y_ready;
    logic [X_W-1:0]         y_out;
    logic [X_W-1:0]         err_out;
    logic                   sat;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [X_W-1:0] tx_x [1:N];
    logic [W_W-1:0] tx_w [0:N];
    logic [X_W-1:0] tx_yt;

    reservoir_readout dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_flat   (x_flat),
        .w_flat   (w_flat),
        .y_target (y_target),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_out    (y_out),
        .err_out  (err_out),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, floor division by 2^6, then clamp to Q1.15.
    task automatic model(output logic [X_W-1:0] ey, output logic [X_W-1:0] ee, output logic es);
        longint s, q, y, d;
        s = longint'($signed(tx_w[0])) * 32768;
        for (int i = 1; i <= N; i++)
            s += longint'($signed(tx_x[i])) * longint'($signed(tx_w[i]));
        q = s / 64;
        if (s < 0 && (s % 64) != 0) q = q - 1;
        es = 1'b0;
        y  = q;
        if (q > 32767)  begin y = 32767;  es = 1'b1; end
        if (q < -32768) begin y = -32768; es = 1'b1; end
        d = longint'($signed(tx_yt)) - y;
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        ey = y[X_W-1:0];
        ee = d[X_W-1:0];
    endtask

    task automatic clear_tx();
        for (int i = 1; i <= N; i++) tx_x[i] = '0;
        for (int i = 0; i <= N; i++) tx_w[i] = '0;
        tx_yt = '0;
    endtask

    task automatic random_tx(input bit small_w);
        for (int i = 1; i <= N; i++) tx_x[i] = X_W'($urandom);
        for (int i = 0; i <= N; i++)
            tx_w[i] = small_w ? W_W'($urandom_range(0, 15) - 8) : W_W'($urandom);
        tx_yt = X_W'($urandom);
    endtask

    task automatic drive_tx();
        for (int i = 1; i <= N; i++) x_flat[(i-1)*X_W +: X_W] = tx_x[i];
        for (int i = 0; i <= N; i++) w_flat[i*W_W +: W_W] = tx_w[i];
        y_target = tx_yt;
    endtask

    task automatic scramble_inputs();
        in_valid = 1'($urandom);
        for (int i = 0; i < N; i++) x_flat[i*X_W +: X_W] = X_W'($urandom);
        for (int i = 0; i <= N; i++) w_flat[i*W_W +: W_W] = W_W'($urandom);
        y_target = X_W'($urandom);
    endtask

    // Called at posedge+1; leaves at posedge+1 after the result handshake.
    task automatic run_tx(input string tag, input bit noise, input int hold_cycles);
        logic [X_W-1:0] ey, ee;
        logic           es;
        int             lat;
        bit             got;
        model(ey, ee, es);
        check({tag, ".ready_before"}, 32'(in_ready), 32'd1);
        drive_tx();
        in_valid = 1'b1;
        y_ready  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            if (noise) scramble_inputs();
            @(posedge clk); #1;
            lat++;
            if (y_valid === 1'b1) got = 1'b1;
        end
        check({tag, ".latency"}, 32'(lat), 32'(N + 1));
        check({tag, ".y_out"},   32'(y_out),   32'(ey));
        check({tag, ".err_out"}, 32'(err_out), 32'(ee));
        check({tag, ".sat"},     32'(sat),     32'(es));
        check({tag, ".busy"},    32'(in_ready), 32'd0);
        for (int c = 0; c < hold_cycles; c++) begin
            if (noise) scramble_inputs();
            @(posedge clk); #1;
            check({tag, ".hold_vld"}, 32'(y_valid),  32'd1);
            check({tag, ".hold_y"},   32'(y_out),    32'(ey));
            check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        y_ready = 1'b1;
        @(posedge clk); #1;
        y_ready  = 1'b0;
        in_valid = 1'b0;
        check({tag, ".vld_drop"}, 32'(y_valid),  32'd0);
        check({tag, ".ready_ret"}, 32'(in_ready), 32'd1);
        if (noise) begin
            @(posedge clk); #1;
            check({tag, ".no_accept"}, 32'(y_valid), 32'd0);
            check({tag, ".idle_stay"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        y_ready  = 1'b0;
        x_flat   = '0;
        w_flat   = '0;
        y_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.y_valid",  32'(y_valid),  32'd0);
        check("rst.y_out",    32'(y_out),    32'd0);
        check("rst.err_out",  32'(err_out),  32'd0);
        check("rst.sat",      32'(sat),      32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unit product: 0.5 * 1.0
        clear_tx();
        tx_x[1] = 16'h4000; tx_w[1] = 8'h40;
        run_tx("t1", 1'b0, 0);
        check("t1.y_const", 32'(y_out), 32'h4000);

        // Bias only
        clear_tx();
        tx_w[0] = 8'h20; tx_yt = 16'h4000;
        run_tx("t2", 1'b0, 1);
        check("t2.err_zero", 32'(err_out), 32'h0);

        // Negative saturation of y and positive saturation of err
        for (int i = 1; i <= N; i++) tx_x[i] = 16'h8000;
        for (int i = 0; i <= N; i++) tx_w[i] = 8'h7F;
        tx_yt = 16'h7FFF;
        run_tx("t3", 1'b0, 0);
        check("t3.y_const",   32'(y_out),   32'h8000);
        check("t3.sat_const", 32'(sat),     32'h1);
        check("t3.err_const", 32'(err_out), 32'h7FFF);

        // Negative operand
        clear_tx();
        tx_x[1] = 16'hC000; tx_w[1] = 8'h40;
        run_tx("t4", 1'b0, 0);
        check("t4.y_const",   32'(y_out),   32'hC000);
        check("t4.err_const", 32'(err_out), 32'h4000);

        // Held output with input noise during MAC/OUT
        random_tx(1'b1);
        run_tx("t5", 1'b1, 5);

        // Reset in the middle of accumulation (idx = 10)
        random_tx(1'b1);
        drive_tx();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("t6.busy_mac", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("t6.in_ready", 32'(in_ready), 32'd1);
        check("t6.y_valid",  32'(y_valid),  32'd0);
        check("t6.y_out",    32'(y_out),    32'd0);
        check("t6.sat",      32'(sat),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6.no_result", 32'(y_valid), 32'd0);
        random_tx(1'b1);
        run_tx("t6.fresh", 1'b0, 0);

        // Randomized transactions, mixing small and full-range weights
        for (int k = 0; k < 12; k++) begin
            random_tx(k[0]);
            run_tx($sformatf("rnd%0d", k), k[1], int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
